// File: rtl/spi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// spi_mem_arbiter
//
// Shares one synchronous SRAM port between the core data interface and the
// SPI slave memory bridge. Round-robin between the two requesters, with an
// SPI lock that keeps the port for multi-word SPI bursts. A lock timeout
// (MAX_LOCK consecutive SPI grants) hands the port back so the core cannot
// starve. Responses come back one cycle after the grant and are routed to
// whichever requester owned that access.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   core_*_i / core_*_o        core request (req/we/addr/wdata/be) and
//                              response (gnt/rvalid/rdata)
//   spi_*_i / spi_*_o          SPI bridge equivalents, plus spi_lock_i
//   mem_*_o / mem_rdata_i      SRAM port; read data valid one cycle after
//                              mem_req_o
//   locked_o                   arbiter is in the LOCKED state
// ---------------------------------------------------------------------------
module spi_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_rdata_o,
    input  logic                spi_req_i,
    input  logic                spi_we_i,
    input  logic [ADDR_W-1:0]   spi_addr_i,
    input  logic [DATA_W-1:0]   spi_wdata_i,
    input  logic [DATA_W/8-1:0] spi_be_i,
    input  logic                spi_lock_i,
    output logic                spi_gnt_o,
    output logic                spi_rvalid_o,
    output logic [DATA_W-1:0]   spi_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                locked_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_LOCK) + 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               last_spi_q, last_spi_d;   // 1: SPI was granted most recently
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;   // SPI grants in the current lock
    logic               rvalid_q, rvalid_d;       // an access was accepted last cycle
    logic               owner_spi_q, owner_spi_d; // that access belonged to SPI

    logic               core_gnt;
    logic               spi_gnt;
    logic               resp_live;

    // Grants are combinational from the live requests and registered state.
    // Reset forces every grant low so nothing reaches the SRAM.
    always_comb begin
        core_gnt = 1'b0;
        spi_gnt  = 1'b0;
        if (!rst_i) begin
            if (state_q == ST_LOCKED) begin
                spi_gnt = spi_req_i;
            end else if (core_req_i && spi_req_i) begin
                // Conflict: the side not granted most recently wins.
                if (last_spi_q) begin
                    core_gnt = 1'b1;
                end else begin
                    spi_gnt = 1'b1;
                end
            end else begin
                core_gnt = core_req_i;
                spi_gnt  = spi_req_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_spi_d  = last_spi_q;
        lock_cnt_d  = lock_cnt_q;
        rvalid_d    = core_gnt | spi_gnt;
        owner_spi_d = spi_gnt;

        if (state_q == ST_ARB) begin
            if (core_gnt) begin
                last_spi_d = 1'b0;
            end
            if (spi_gnt) begin
                last_spi_d = 1'b1;
                if (spi_lock_i) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = CNT_W'(1);
                end
            end
        end else begin
            if (spi_gnt && (lock_cnt_q == LOCK_LAST)) begin
                // Timeout: leave with SPI marked as most recent so a
                // waiting core wins the next conflict.
                state_d    = ST_ARB;
                last_spi_d = 1'b1;
                lock_cnt_d = '0;
            end else begin
                if (spi_gnt) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
                // A grant in the same cycle as the lock drop still happens;
                // the return to ARB takes effect at the edge.
                if (!spi_lock_i) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_ARB;
            last_spi_q  <= 1'b1;
            lock_cnt_q  <= '0;
            rvalid_q    <= 1'b0;
            owner_spi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_spi_q  <= last_spi_d;
            lock_cnt_q  <= lock_cnt_d;
            rvalid_q    <= rvalid_d;
            owner_spi_q <= owner_spi_d;
        end
    end

    // SRAM port follows the winner; idle cycles drive zeros.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (core_gnt) begin
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
            mem_be_o    = core_be_i;
        end else if (spi_gnt) begin
            mem_we_o    = spi_we_i;
            mem_addr_o  = spi_addr_i;
            mem_wdata_o = spi_wdata_i;
            mem_be_o    = spi_be_i;
        end
    end

    assign mem_req_o  = core_gnt | spi_gnt;
    assign core_gnt_o = core_gnt;
    assign spi_gnt_o  = spi_gnt;

    // The response is gated by reset as well, so a response that was in
    // flight when reset arrived is never seen.
    assign resp_live     = rvalid_q & ~rst_i;
    assign core_rvalid_o = resp_live & ~owner_spi_q;
    assign spi_rvalid_o  = resp_live &  owner_spi_q;
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    assign spi_rdata_o   = spi_rvalid_o  ? mem_rdata_i : '0;

    assign locked_o = (state_q == ST_LOCKED) & ~rst_i;

    logic unused_be_w;
    assign unused_be_w = (BE_W == 0);

endmodule
